// File: rtl/mux8t1_32_pkg.sv
// mux8t1_32_pkg
// Shared select-width constants for the 8:1 word mux and its 4:1 leaves.
// No ports; imported by mux8t1_32 and mux4t1.
package mux8t1_32_pkg;

    // Top-level select: binary index 0..7.
    localparam int unsigned SEL_W      = 3;
    // Leaf select: the low two bits of the top-level select.
    localparam int unsigned LEAF_SEL_W = 2;

endpackage : mux8t1_32_pkg

// File: rtl/mux8t1_32_mux4t1.sv
// mux4t1
// Combinational 4-to-1 word multiplexer, first level of the 8:1 select tree.
// Ports:
//   s       in  LEAF_SEL_W  binary select 0..3
//   I0..I3  in  WIDTH       data inputs, In chosen when s == n
//   o       out WIDTH       selected word, passed through unchanged
module mux4t1
    import mux8t1_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [LEAF_SEL_W-1:0] s,
    input  logic [WIDTH-1:0]      I0,
    input  logic [WIDTH-1:0]      I1,
    input  logic [WIDTH-1:0]      I2,
    input  logic [WIDTH-1:0]      I3,
    output logic [WIDTH-1:0]      o
);

    // Every code is decoded, so unselected inputs (even X/Z) never reach o.
    always_comb begin
        o = '0;
        unique case (s)
            2'd0: o = I0;
            2'd1: o = I1;
            2'd2: o = I2;
            2'd3: o = I3;
        endcase
    end

endmodule : mux4t1

// File: rtl/mux8t1_32.sv
// mux8t1_32
// Registered 8-to-1 word multiplexer. Two 4:1 leaves share s[1:0]; s[2]
// chooses between them and the result is registered into o every cycle.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_n   in  1      synchronous active-low reset, clears o
//   s       in  3      binary select 0..7
//   I0..I7  in  WIDTH  data inputs, In chosen when s == n
//   o       out WIDTH  registered selected word, one cycle latency
module mux8t1_32
    import mux8t1_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] s,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] lo_sel;
    logic [WIDTH-1:0] hi_sel;
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;

    mux4t1 #(.WIDTH(WIDTH)) u_mux_lo (
        .s  (s[LEAF_SEL_W-1:0]),
        .I0 (I0),
        .I1 (I1),
        .I2 (I2),
        .I3 (I3),
        .o  (lo_sel)
    );

    mux4t1 #(.WIDTH(WIDTH)) u_mux_hi (
        .s  (s[LEAF_SEL_W-1:0]),
        .I0 (I4),
        .I1 (I5),
        .I2 (I6),
        .I3 (I7),
        .o  (hi_sel)
    );

    always_comb begin
        o_d = s[SEL_W-1] ? hi_sel : lo_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign o = o_q;

endmodule : mux8t1_32

// File: tb/tb_mux8t1_32.sv
// tb_mux8t1_32
// Scoreboard bench for mux8t1_32: the driver applies one vector per cycle
// and queues the expected o; the monitor pops and compares after each edge.
module tb_mux8t1_32;

    logic        clk;
    logic        rst_n;
    logic [2:0]  s;
    logic [31:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic [31:0] o;

    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    mux8t1_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
        .I4    (I4),
        .I5    (I5),
        .I6    (I6),
        .I7    (I7),
        .o     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: o=%h expected %h", name, act, req);
        end
    endtask

    task automatic set_std_inputs();
        I0 = 32'hAA550000; I1 = 32'h55AA1111; I2 = 32'hAA552222; I3 = 32'h55AA3333;
        I4 = 32'hAA554444; I5 = 32'h55AA5555; I6 = 32'hAA556666; I7 = 32'h55AA7777;
    endtask

    // Called at a falling edge: applies the vector, queues the expected
    // output for the coming rising edge, and returns at the next falling edge.
    task automatic drive(input logic [2:0] sel, input logic rst, input logic [31:0] exp);
        s     = sel;
        rst_n = rst;
        exp_q.push_back(exp);
        @(negedge clk);
    endtask

    // Monitor: the register updates on every rising edge, so each edge with a
    // pending expectation is one output to check.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("scoreboard", o, e);
        end
    end

    initial begin
        logic [31:0] table_v [8];
        logic [3:0]  wide_sel;
        int          wait_cnt;

        table_v[0] = 32'hAA550000; table_v[1] = 32'h55AA1111;
        table_v[2] = 32'hAA552222; table_v[3] = 32'h55AA3333;
        table_v[4] = 32'hAA554444; table_v[5] = 32'h55AA5555;
        table_v[6] = 32'hAA556666; table_v[7] = 32'h55AA7777;

        set_std_inputs();
        s     = 3'd5;
        rst_n = 1'b0;
        @(negedge clk);

        // 1: reset held for two edges, then release loads the selection.
        drive(3'd5, 1'b0, 32'h00000000);
        drive(3'd5, 1'b0, 32'h00000000);
        drive(3'd5, 1'b1, 32'h55AA5555);

        // 2: sweep every select code, five cycles each.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 5; k++) begin
                drive(3'(i), 1'b1, table_v[i]);
            end
        end

        // 3: a 4-bit select of 8 truncates to index 0.
        wide_sel = 4'd8;
        drive(wide_sel[2:0], 1'b1, 32'hAA550000);
        drive(3'd0, 1'b1, 32'hAA550000);

        // 4: unselected inputs at X must not leak into o.
        I0 = 'x; I1 = 'x; I3 = 'x; I4 = 'x; I5 = 'x; I6 = 'x; I7 = 'x;
        I2 = 32'hDEADBEEF;
        drive(3'd2, 1'b1, 32'hDEADBEEF);
        checks++;
        if ($isunknown(o)) begin
            errors++;
            $display("FAIL x_free: o=%h expected no X bits", o);
        end
        set_std_inputs();

        // 5: reset asserted between edges leaves o alone until the edge.
        drive(3'd7, 1'b1, 32'h55AA7777);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_between_edges", o, 32'h55AA7777);
        @(negedge clk);
        drive(3'd7, 1'b0, 32'h00000000);

        // 6: select and data change in the same cycle.
        drive(3'd1, 1'b1, 32'h55AA1111);
        I4 = 32'h12345678;
        drive(3'd4, 1'b1, 32'h12345678);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux8t1_32
